// File: rtl/transfer_controller.sv
// transfer_controller: sequences a signed element-wise max of memory 1 into memory 2
module transfer_controller #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_mem_data1,
  input  logic [DATA_W-1:0] i_mem_data2,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_dout1,
  output logic [DATA_W-1:0] o_dout2,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we2,
  output logic [DATA_W-1:0] o_wr_data2,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CMP, S_WRITE, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t              r_state;
  state_t              w_next;
  logic                w_adv;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic [DATA_W-1:0]   r_dout1;
  logic [DATA_W-1:0]   r_dout2;
  // next state; advance leaves CMP without a write or WRITE, stopping at the last address
  always_comb begin
    w_adv  = (r_state == S_CMP && !i_sign) || r_state == S_WRITE;
    w_next = r_state == S_IDLE ? (i_start ? S_READ : S_IDLE)
           : r_state == S_READ ? S_CMP
           : (r_state == S_CMP && i_sign) ? S_WRITE
           : w_adv ? (r_addr == LAST ? S_DONE : S_READ)
           : S_IDLE;
  end
  // state, address/index, word registers and write count
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_dout1 <= '0;
      r_dout2 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) r_count <= '0;
      if (r_state == S_DONE) r_addr <= '0;
      if (w_adv && r_addr != LAST) r_addr <= r_addr + ADDR_W'(1);
      if (r_state == S_READ) begin
        r_dout1 <= i_mem_data1;
        r_dout2 <= i_mem_data2;
      end
      if (r_state == S_WRITE) r_count <= r_count + (ADDR_W + 1)'(1);
    end
  end
  assign o_dout1    = r_dout1;
  assign o_dout2    = r_dout2;
  assign o_addr     = r_addr;
  assign o_we2      = r_state == S_WRITE && !i_reset;
  assign o_wr_data2 = r_dout1;
  assign o_busy     = r_state == S_READ || r_state == S_CMP || r_state == S_WRITE;
  assign o_done     = r_state == S_DONE;
  assign o_count    = r_count;
endmodule

// File: tb/tb_transfer_controller.sv
// tb_transfer_controller: scoreboard bench with memory and comparator models around the sequencer
module tb_transfer_controller;
  typedef struct {logic [2:0] a; logic [7:0] d;} wr_t;
  logic clk = 0, rst = 1, start = 0, ld = 0;
  logic sign, we2, busy, done;
  logic [7:0] md1, md2, dout1, dout2, wd2;
  logic [2:0] addr;
  logic [3:0] count;
  logic [7:0] mem1 [8];
  logic [7:0] mem2 [8];
  logic [7:0] ld_vals [8];
  logic [7:0] exp_mem [8];
  int checks = 0, errors = 0, cyc = 0, c0 = 0;
  wr_t q[$];
  always #5 clk = ~clk;
  transfer_controller #(.ADDR_W(3), .DATA_W(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_mem_data1(md1), .i_mem_data2(md2),
    .i_sign(sign), .o_dout1(dout1), .o_dout2(dout2), .o_addr(addr), .o_we2(we2),
    .o_wr_data2(wd2), .o_busy(busy), .o_done(done), .o_count(count)
  );
  assign md1  = mem1[addr];
  assign md2  = mem2[addr];
  assign sign = $signed(dout2) < $signed(dout1);
  // memory 2: bench preload or DUT write on the rising edge
  always @(posedge clk) begin
    if (ld) mem2 <= ld_vals;
    else if (we2) mem2[addr] <= wd2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (we2) begin
      if (q.size() == 0) chk("we2_unexpected", 32'(we2), 0);
      else begin
        e = q.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_data", 32'(wd2), 32'(e.d));
      end
    end
  endtask
  task automatic build();
    q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = $signed(mem1[i]) > $signed(mem2[i]) ? mem1[i] : mem2[i];
      if ($signed(mem1[i]) > $signed(mem2[i])) q.push_back(wr_t'{3'(i), mem1[i]});
    end
  endtask
  task automatic do_load();
    ld = 1;
    tick();
    ld = 0;
  endtask
  task automatic begin_pass(input string tag);
    build();
    start = 1;
    c0 = cyc;
    tick();
    chk({tag, "_addr_c1"}, 32'(addr), 0);
    chk({tag, "_busy_c1"}, 32'(busy), 1);
    chk({tag, "_count_c1"}, 32'(count), 0);
    start = 0;
  endtask
  task automatic wait_done(input string tag, input int exp_done, input int exp_count, input int pulse_at, input bit hold);
    for (int n = 0; n < 60 && !done; n++) begin
      if (cyc - c0 == pulse_at) start = 1;
      if (cyc - c0 == pulse_at + 1) start = 0;
      if (hold && cyc - c0 == exp_done - 1) start = 1;
      tick();
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
    chk({tag, "_done_cycle"}, 32'(cyc - c0), 32'(exp_done));
    chk({tag, "_count"}, 32'(count), 32'(exp_count));
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_writes_left"}, 32'(q.size()), 0);
  endtask
  task automatic chk_mem(input string tag);
    for (int i = 0; i < 8; i++) chk({tag, "_mem2"}, 32'(mem2[i]), 32'(exp_mem[i]));
  endtask
  initial begin
    mem1 = '{default: 8'h00};
    ld_vals = '{default: 8'h00};
    ld = 1;
    tick();
    tick();
    ld = 0;
    tick();
    chk("rst_dout1", 32'(dout1), 0);
    chk("rst_dout2", 32'(dout2), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_we2", 32'(we2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    rst = 0;
    tick();
    begin_pass("t1");
    wait_done("t1", 17, 0, 0, 0);
    chk_mem("t1");
    tick();
    mem1 = '{default: 8'h7F};
    ld_vals = '{default: 8'h80};
    do_load();
    begin_pass("t2");
    wait_done("t2", 25, 8, 0, 0);
    chk_mem("t2");
    chk("t2_mem2_0", 32'(mem2[0]), 'h7F);
    tick();
    mem1 = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00};
    ld_vals = '{8'h00, 8'h7F, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00};
    do_load();
    begin_pass("t3");
    wait_done("t3", 18, 1, 0, 0);
    chk_mem("t3");
    chk("t3_mem2_3", 32'(mem2[3]), 'hFF);
    tick();
    mem1 = '{default: 8'h10};
    ld_vals = '{default: 8'h00};
    do_load();
    begin_pass("t4");
    while (cyc - c0 < 9) tick();
    chk("t4_we2_addr2", 32'(we2), 1);
    chk("t4_addr2", 32'(addr), 2);
    rst = 1;
    tick();
    chk("t4_dout1", 32'(dout1), 0);
    chk("t4_dout2", 32'(dout2), 0);
    chk("t4_addr", 32'(addr), 0);
    chk("t4_we2", 32'(we2), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_count", 32'(count), 0);
    chk("t4_pending", 32'(q.size()), 5);
    chk("t4_mem2_2", 32'(mem2[2]), 0);
    chk("t4_mem2_1", 32'(mem2[1]), 'h10);
    q.delete();
    tick();
    rst = 0;
    tick();
    begin_pass("t4b");
    wait_done("t4b", 23, 6, 0, 0);
    chk_mem("t4b");
    tick();
    mem1 = '{default: 8'h05};
    ld_vals = '{default: 8'h03};
    do_load();
    begin_pass("t5");
    wait_done("t5", 25, 8, 5, 1);
    chk_mem("t5");
    tick();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_count", 32'(count), 8);
    build();
    tick();
    chk("t5_restart_busy", 32'(busy), 1);
    chk("t5_restart_addr", 32'(addr), 0);
    chk("t5_restart_count", 32'(count), 0);
    start = 0;
    c0 = cyc - 1;
    wait_done("t5b", 17, 0, 0, 0);
    chk_mem("t5b");
    tick();
    mem1 = '{default: 8'h80};
    ld_vals = '{default: 8'h7F};
    do_load();
    begin_pass("t6");
    wait_done("t6", 17, 0, 0, 0);
    chk_mem("t6");
    tick();
    begin_pass("t6b");
    wait_done("t6b", 17, 0, 0, 0);
    chk_mem("t6b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
